// File: rtl/octal_tick_counter.sv
// Prescaled 3-bit up/down counter with run/stop FSM, clear, load and wrap flag.
// Feeds the 7-segment decoder stage with one step per DIV enabled cycles.
module octal_tick_counter #(
    parameter int DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       clr,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       up_dn,
    output logic [2:0] bcd,
    output logic       tick,
    output logic       wrap,
    output logic       running
);

    localparam int W = (DIV <= 1) ? 1 : $clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [W-1:0] div_cnt;
    logic         en;
    logic         step;
    logic         wrap_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_STOP;
        end else begin
            state_q <= state_d;
        end
    end

    // stop dominates start in both states
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_STOP: if (start && !stop) state_d = ST_RUN;
            ST_RUN:  if (stop)           state_d = ST_STOP;
            default:                     state_d = ST_STOP;
        endcase
    end

    assign running  = (state_q == ST_RUN);
    assign en       = running && !stop;
    assign step     = en && (div_cnt == LAST);
    assign wrap_hit = up_dn ? (bcd == 3'd7) : (bcd == 3'd0);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            bcd     <= 3'd0;
            div_cnt <= '0;
            tick    <= 1'b0;
            wrap    <= 1'b0;
        end else if (load) begin
            bcd     <= load_val;
            div_cnt <= '0;
            tick    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            tick <= step;
            wrap <= step && wrap_hit;
            if (en) begin
                div_cnt <= step ? '0 : div_cnt + W'(1);
            end
            if (step) begin
                bcd <= up_dn ? bcd + 3'd1 : bcd - 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_octal_tick_counter.sv
// Randomized and directed bench for octal_tick_counter (DIV=4) against a
// behavioural reference model evaluated once per clock edge.
module tb_octal_tick_counter;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [2:0] load_val = 3'd0;
    logic       up_dn = 1'b1;
    logic [2:0] bcd;
    logic       tick;
    logic       wrap;
    logic       running;

    int errs = 0;
    int checks = 0;

    bit m_run = 1'b0;
    int m_cnt = 0;
    int m_bcd = 0;
    bit m_tick = 1'b0;
    bit m_wrap = 1'b0;

    octal_tick_counter #(.DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .up_dn    (up_dn),
        .bcd      (bcd),
        .tick     (tick),
        .wrap     (wrap),
        .running  (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errs++;
            $display("FAIL %s: got %0d, want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: rules applied to the values seen at the edge.
    task automatic model_edge();
        bit en;
        bit stp;
        if (rst) begin
            m_run = 0; m_cnt = 0; m_bcd = 0; m_tick = 0; m_wrap = 0;
            return;
        end
        en  = m_run && !stop;
        stp = en && (m_cnt == DIV - 1);
        if (stop) m_run = 0;
        else if (start) m_run = 1;
        if (clr) begin
            m_bcd = 0; m_cnt = 0; m_tick = 0; m_wrap = 0;
        end else if (load) begin
            m_bcd = int'(load_val); m_cnt = 0; m_tick = 0; m_wrap = 0;
        end else begin
            m_tick = stp;
            m_wrap = stp && (up_dn ? (m_bcd == 7) : (m_bcd == 0));
            if (en) m_cnt = stp ? 0 : m_cnt + 1;
            if (stp) m_bcd = up_dn ? (m_bcd + 1) % 8 : (m_bcd + 7) % 8;
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        model_edge();
        #1;
        check("bcd", int'(bcd), m_bcd);
        check("tick", int'(tick), int'(m_tick));
        check("wrap", int'(wrap), int'(m_wrap));
        check("running", int'(running), int'(m_run));
        rst = 0; start = 0; stop = 0; clr = 0; load = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) clk1();
    endtask

    task automatic do_load(input logic [2:0] v);
        load_val = v;
        load = 1;
        clk1();
    endtask

    initial begin
        // reset then start
        rst = 1; clk1();
        rst = 1; clk1();
        check("rst_bcd", int'(bcd), 0);
        check("rst_run", int'(running), 0);
        check("rst_tick", int'(tick), 0);
        up_dn = 1;
        start = 1; clk1();
        check("start_run", int'(running), 1);
        idle(3);
        check("pre_tick", int'(tick), 0);
        idle(1);
        check("tick1", int'(tick), 1);
        check("bcd1", int'(bcd), 1);
        idle(1);
        check("tick_width", int'(tick), 0);
        idle(7);
        check("bcd3", int'(bcd), 3);
        check("tick3", int'(tick), 1);

        // up wrap
        do_load(3'd6);
        check("load6", int'(bcd), 6);
        idle(4);
        check("up7", int'(bcd), 7);
        check("up7_wrap", int'(wrap), 0);
        idle(4);
        check("up0", int'(bcd), 0);
        check("up_wrap", int'(wrap), 1);
        check("up_wrap_tick", int'(tick), 1);

        // down wrap
        up_dn = 0;
        do_load(3'd1);
        idle(4);
        check("dn0", int'(bcd), 0);
        check("dn0_wrap", int'(wrap), 0);
        idle(4);
        check("dn7", int'(bcd), 7);
        check("dn_wrap", int'(wrap), 1);

        // pause and resume mid-period
        up_dn = 1;
        do_load(3'd2);
        idle(2);
        stop = 1; clk1();
        check("stop_run", int'(running), 0);
        idle(10);
        check("frozen", int'(bcd), 2);
        start = 1; clk1();
        idle(1);
        check("resume_early", int'(tick), 0);
        idle(1);
        check("resume_tick", int'(tick), 1);
        check("resume_bcd", int'(bcd), 3);

        // collisions on a step-due cycle
        idle(3);
        clr = 1; clk1();
        check("clr_bcd", int'(bcd), 0);
        check("clr_tick", int'(tick), 0);
        idle(3);
        load_val = 3'd5; load = 1; clk1();
        check("ld_bcd", int'(bcd), 5);
        check("ld_tick", int'(tick), 0);
        stop = 1; clk1();
        start = 1; stop = 1; clk1();
        check("both_run", int'(running), 0);

        // reset mid-run
        do_load(3'd3);
        start = 1; clk1();
        idle(2);
        check("pre_rst_bcd", int'(bcd), 3);
        rst = 1; start = 1; load = 1; load_val = 3'd6; clk1();
        check("mr_bcd", int'(bcd), 0);
        check("mr_run", int'(running), 0);
        check("mr_tick", int'(tick), 0);
        check("mr_wrap", int'(wrap), 0);
        idle(8);
        check("no_step", int'(bcd), 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 59) == 0);
            start    = ($urandom_range(0, 5) == 0);
            stop     = ($urandom_range(0, 11) == 0);
            clr      = ($urandom_range(0, 29) == 0);
            load     = ($urandom_range(0, 19) == 0);
            load_val = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 14) == 0) up_dn = ~up_dn;
            clk1();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
